uart_tx_arbiter: RTL and testbench

//  Shares one UART byte serializer among N_REQ byte sources. Round-robin grant per byte

---
 rtl/uart_tx_arbiter.sv | 149 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte serializer among N_REQ valid/ready byte sources.
// Define UART_ARB_LOCK_EN to keep multi-byte messages (req_last terminated) from interleaving.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*DATA_W-1:0]  req_data,
  input  logic [N_REQ-1:0]         req_last,
  output logic [N_REQ-1:0]         req_ready,
  output logic [DATA_W-1:0]        tx_data,
  output logic                     tx_valid,
  input  logic                     tx_done,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] grant_id
);

  localparam int unsigned ID_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_SEND  = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [N_REQ-1:0]  ready_q, ready_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              busy_q, busy_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   rr_q, rr_d;

  logic [N_REQ-1:0]  elig;
  logic              win_found;
  logic [ID_W-1:0]   win_id;
  logic [ID_W:0]     cand_sum;
  logic [ID_W-1:0]   cand_id;
  logic [DATA_W-1:0] req_bytes [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign req_bytes[gi] = req_data[gi*DATA_W +: DATA_W];
  end

`ifdef UART_ARB_LOCK_EN
  logic lock_q, lock_d;

  // While a message is open only its owner (held in rr_q) may be granted.
  always_comb begin
    elig = req_valid;
    if (lock_q) elig = req_valid & (N_REQ'(1) << rr_q);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) lock_q <= 1'b0;
    else       lock_q <= lock_d;
  end
`else
  logic unused_last;
  assign unused_last = ^req_last;
  assign elig        = req_valid;
`endif

  // First eligible index after the rr pointer, wrapping modulo N_REQ.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand_sum  = '0;
    cand_id   = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand_sum = {1'b0, rr_q} + (ID_W+1)'(k);
      if (cand_sum >= (ID_W+1)'(N_REQ)) cand_sum = cand_sum - (ID_W+1)'(N_REQ);
      cand_id = cand_sum[ID_W-1:0];
      if (!win_found && elig[cand_id]) begin
        win_found = 1'b1;
        win_id    = cand_id;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ready_d    = '0;
    tx_valid_d = 1'b0;
    tx_data_d  = tx_data_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
`ifdef UART_ARB_LOCK_EN
    lock_d     = lock_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d = S_GRANT;
          grant_d = win_id;
          ready_d = N_REQ'(1) << win_id;
        end
      end
      S_GRANT: begin
        // A requester that dropped valid before its handshake gets nothing sent.
        if (req_valid[grant_q]) begin
          state_d    = S_SEND;
          tx_valid_d = 1'b1;
          tx_data_d  = req_bytes[grant_q];
          rr_d       = grant_q;
`ifdef UART_ARB_LOCK_EN
          lock_d     = !req_last[grant_q];
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND:  state_d = S_WAIT;
      S_WAIT:  if (tx_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= S_IDLE;
      ready_q    <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      grant_q    <= '0;
      rr_q       <= ID_W'(N_REQ - 1);
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
    end
  end

  assign req_ready = ready_q;
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign busy      = busy_q;
  assign grant_id  = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios and randomized traffic
// checked against a frame-level round-robin model; a 3-requester instance checks index range.
module tb_uart_tx_arbiter;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int DEPTH = 64;
`ifdef UART_ARB_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic           clk;
  logic           nrst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   tx_data;
  logic           tx_valid;
  logic           tx_done;
  logic           busy;
  logic [1:0]     grant_id;

  logic [2:0]     v3, l3, r3;
  logic [23:0]    d3;
  logic [7:0]     txd3;
  logic           txv3, done3, busy3;
  logic [1:0]     gid3;

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(W)) u_dut (
    .clk(clk), .nrst(nrst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_done(tx_done),
    .busy(busy), .grant_id(grant_id)
  );

  uart_tx_arbiter #(.N_REQ(3), .DATA_W(8)) u_dut3 (
    .clk(clk), .nrst(nrst), .req_valid(v3), .req_data(d3), .req_last(l3),
    .req_ready(r3), .tx_data(txd3), .tx_valid(txv3), .tx_done(done3),
    .busy(busy3), .grant_id(gid3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert;
  int n_fail;

  // Requester byte queues (head/tail indexed) and frame-level arbiter model.
  logic [W-1:0] byte_mem [N][DEPTH];
  bit           last_mem [N][DEPTH];
  int           head [N];
  int           tail [N];
  int           rr_m, lock_id_m, pop_pend, wait_cnt;
  bit           lock_m, arb_ok, txv_due, in_wait, done_flag, inject_send_done;
  logic [W-1:0] cur_byte, exp_byte;
  int           grant_log [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int i, input logic [W-1:0] b, input bit last);
    if (tail[i] < DEPTH) begin
      byte_mem[i][tail[i]] = b;
      last_mem[i][tail[i]] = last;
      tail[i]++;
    end
  endtask

  task automatic push_msg(input int i);
    int n;
    n = $urandom_range(1, 3);
    for (int b = 0; b < n; b++) push(i, W'($urandom), b == n - 1);
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      if (head[i] < tail[i]) begin
        req_valid[i]       = 1'b1;
        req_data[i*W +: W] = byte_mem[i][head[i]];
        req_last[i]        = last_mem[i][head[i]];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[i*W +: W] = '0;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  function automatic int model_pick(input logic [N-1:0] v);
    int g;
    int idx;
    g = -1;
    for (int k = 1; k <= N; k++) begin
      idx = (rr_m + k) % N;
      if (g < 0 && v[idx] && (!lock_m || idx == lock_id_m)) g = idx;
    end
    return g;
  endfunction

  function automatic bit model_busy();
    bit pend;
    pend = 1'b0;
    for (int i = 0; i < N; i++) if (head[i] < tail[i]) pend = 1'b1;
    return pend || in_wait || txv_due || done_flag || (pop_pend >= 0) || !arb_ok;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    rr_m = N - 1; lock_m = 1'b0; lock_id_m = 0; arb_ok = 1'b0; txv_due = 1'b0;
    in_wait = 1'b0; done_flag = 1'b0; inject_send_done = 1'b0; pop_pend = -1; wait_cnt = 0;
    grant_log.delete();
    req_valid = '0; req_data = '0; req_last = '0; tx_done = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_txv"},   32'(tx_valid),  32'd0);
    chk({tag, "_txd"},   32'(tx_data),   32'd0);
    chk({tag, "_busy"},  32'(busy),      32'd0);
    chk({tag, "_gid"},   32'(grant_id),  32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 nrst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    nrst   = 1'b1;
    arb_ok = 1'b1;
  endtask

  // One cycle: check outputs at the negedge, then play requesters and serializer.
  task automatic step();
    int           g;
    logic [N-1:0] exp_ready;
    bit           new_wait, nxt_txv;
    logic [W-1:0] nxt_byte;
    @(negedge clk);
    g         = arb_ok ? model_pick(req_valid) : -1;
    exp_ready = '0;
    nxt_txv   = 1'b0;
    nxt_byte  = exp_byte;
    if (g >= 0) exp_ready[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    if (g >= 0) begin
      chk("grant_id", 32'(grant_id), 32'(g));
      chk("busy_grant", 32'(busy), 32'd1);
      grant_log.push_back(g);
      if (LOCK) begin
        lock_m    = !last_mem[g][head[g]];
        lock_id_m = g;
      end
      rr_m     = g;
      nxt_byte = byte_mem[g][head[g]];
      nxt_txv  = 1'b1;
      arb_ok   = 1'b0;
    end
    chk("tx_valid", 32'(tx_valid), 32'(txv_due));
    new_wait = 1'b0;
    if (txv_due) begin
      chk("tx_data_send", 32'(tx_data), 32'(exp_byte));
      chk("busy_send", 32'(busy), 32'd1);
      in_wait  = 1'b1;
      cur_byte = exp_byte;
      wait_cnt = $urandom_range(1, 5);
      new_wait = 1'b1;
    end else if (in_wait) begin
      chk("tx_data_hold", 32'(tx_data), 32'(cur_byte));
      chk("busy_wait", 32'(busy), 32'd1);
    end
    if (done_flag) begin
      chk("busy_after_done", 32'(busy), 32'd0);
      done_flag = 1'b0;
      arb_ok    = 1'b1;
    end
    txv_due  = nxt_txv;
    exp_byte = nxt_byte;
    tx_done  = 1'b0;
    if (new_wait && inject_send_done) begin
      tx_done          = 1'b1;
      inject_send_done = 1'b0;
    end else if (in_wait && !new_wait) begin
      wait_cnt--;
      if (wait_cnt <= 0) begin
        tx_done   = 1'b1;
        in_wait   = 1'b0;
        done_flag = 1'b1;
      end
    end
    if (pop_pend >= 0) head[pop_pend]++;
    pop_pend = g;
    drive_reqs();
  endtask

  task automatic drain(input string tag, input int max_cyc);
    int c;
    c = 0;
    while (model_busy() && c < max_cyc) begin
      step();
      c++;
    end
    chk({tag, "_drain_timeout"}, 32'(c < max_cyc), 32'd1);
  endtask

  task automatic check_order(input string tag, input int exp [5], input int n);
    chk({tag, "_count"}, 32'(grant_log.size()), 32'(n));
    for (int i = 0; i < n && i < grant_log.size(); i++)
      chk({tag, "_order"}, 32'(grant_log[i]), 32'(exp[i]));
  endtask

  initial begin
    int exp_ord [5];
    n_assert = 0;
    n_fail   = 0;
    exp_byte = '0;
    cur_byte = '0;
    v3 = '0; d3 = '0; l3 = '0; done3 = 1'b0;
    nrst = 1'b0;
    model_reset();
    #1 check_zero("reset_async");
    repeat (2) @(negedge clk);
    check_zero("reset_hold");
    nrst   = 1'b1;
    arb_ok = 1'b1;

    // Single byte: latency, tx_data stable through the frame.
    push(0, 8'h55, 1'b1);
    drive_reqs();
    drain("t1", 100);
    exp_ord = '{0, 0, 0, 0, 0};
    check_order("t1", exp_ord, 1);

    // All four requesters held: strict rotation starting from 0.
    do_reset();
    push(0, 8'hA0, 1'b1); push(1, 8'hA1, 1'b1); push(2, 8'hA2, 1'b1); push(3, 8'hA3, 1'b1);
    push(0, 8'hA4, 1'b1);
    drive_reqs();
    drain("t2", 200);
    exp_ord = '{0, 1, 2, 3, 0};
    check_order("t2", exp_ord, 5);

    // Wrap: after grant to 1, requesters 3 and 1 -> 3 first, then 1.
    do_reset();
    push(1, 8'h11, 1'b1);
    drive_reqs();
    drain("t3a", 100);
    push(3, 8'h33, 1'b1); push(1, 8'h12, 1'b1);
    drive_reqs();
    drain("t3b", 100);
    exp_ord = '{1, 3, 1, 0, 0};
    check_order("t3", exp_ord, 3);

    // Three-byte message on 0 against a steady requester 1.
    do_reset();
    push(0, 8'hB0, 1'b0); push(0, 8'hB1, 1'b0); push(0, 8'hB2, 1'b1);
    push(1, 8'hC0, 1'b1); push(1, 8'hC1, 1'b1);
    drive_reqs();
    drain("t4", 300);
    if (LOCK) exp_ord = '{0, 0, 0, 1, 1};
    else      exp_ord = '{0, 1, 0, 1, 0};
    check_order("t4", exp_ord, 5);

    // Stray tx_done in IDLE and in SEND must not move the FSM.
    tx_done = 1'b1;
    step();
    chk("t6_idle_busy", 32'(busy), 32'd0);
    inject_send_done = 1'b1;
    push(2, 8'h66, 1'b1);
    drive_reqs();
    drain("t6", 100);

    // Asynchronous reset in WAIT, then a fresh grant to requester 2.
    do_reset();
    push(1, 8'h77, 1'b1);
    drive_reqs();
    for (int c = 0; c < 10 && !(in_wait && !txv_due); c++) step();
    chk("t5_reached_wait", 32'(in_wait), 32'd1);
    wait_cnt = 50;
    step();
    #2 nrst = 1'b0;
    #1 check_zero("t5_rst");
    model_reset();
    @(negedge clk);
    nrst   = 1'b1;
    arb_ok = 1'b1;
    push(2, 8'h5A, 1'b1);
    drive_reqs();
    drain("t5", 100);
    exp_ord = '{2, 0, 0, 0, 0};
    check_order("t5", exp_ord, 1);

    // Random messages, all queued up front.
    do_reset();
    for (int i = 0; i < N; i++) begin
      int m;
      m = $urandom_range(1, 3);
      for (int k = 0; k < m; k++) push_msg(i);
    end
    drive_reqs();
    drain("rnd_a", 3000);

    // Random messages arriving while traffic is running.
    for (int c = 0; c < 150; c++) begin
      step();
      if ($urandom_range(0, 9) == 0) begin
        push_msg($urandom_range(0, N - 1));
        drive_reqs();
      end
    end
    drain("rnd_b", 3000);

    // Three-requester instance: grant index must stay below 3.
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      chk("n3_grant_range", 32'(gid3 < 2'd3), 32'd1);
      chk("n3_ready_onehot", 32'($countones(r3) <= 1), 32'd1);
      v3    = 3'($urandom);
      d3    = 24'($urandom);
      l3    = 3'($urandom);
      done3 = ($urandom_range(0, 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
